uart_hamming_transmitter: RTL and testbench
===========================================

# uart_hamming_transmitter

Serial transmit side of the Hamming(7,4) UART link. Accepts a 4-bit nibble over a valid/ready handshake and encodes it into a 7-bit Hamming codeword. Sends the codeword as an idle-high UART frame (start, 7 data bits LSB first, stop), paced by the same `ena` oversampling tick the link's receiver uses. A one-entry holding register allows back-to-back frames with no idle gap.

## Interface
- `SAMPLES_PER_BIT`, default 8: `ena` ticks per serial bit. Must be a power of two, ≥2. Receiver interoperability requires 8.
- `STOP_BITS`, default 1: number of stop bits per frame (1 or 2).
- `clk`  in  1  clock; one clock domain, all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `ena`  in  1  oversampling tick; frame sequencing advances only on cycles with `ena`=1.
- `data_in`  in  4  nibble to send, d[3:0].
- `data_valid`  in  1  `data_in` is valid this cycle.
- `data_ready`  out  1  holding register is empty; a nibble is accepted when `data_valid & data_ready`.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  a frame is on the line (state ≠ IDLE).
- `frame_done`  out  1  one-cycle pulse on the last tick of the final stop bit.
- `state_out`  out  2  current state, for debug.

## Operation
- Encoding, computed from the nibble when it moves into the shift register:
  - p1 = d0^d1^d3, p2 = d0^d2^d3, p4 = d1^d2^d3.
  - c[6:0] = {d3, d2, d1, p4, d0, p2, p1}.
  - c[0] is transmitted first.
- Handshake:
  - An accept loads `hold` and sets `hold_full`. On the next clock, `data_ready` = 0.
  - `data_ready` = !`hold_full`, driven from a register. There is no same-cycle bypass from emptying to refilling.
  - Accepts happen on any clock, independent of `ena` and of the current state.
- States (`state_out`): IDLE=0, START=1, DATA=2, STOP=3.
- Sample counter `sc` (log2(SAMPLES_PER_BIT) bits), bit counter `bc` (3 bits). Both change only on `ena` cycles.
- IDLE:
  - `tx`=1.
  - On an `ena` cycle with `hold_full`=1: load the encoded `hold` into the shift register, clear `hold_full`, set `sc`=0, go to START.
- START:
  - `tx`=0.
  - When `sc`=SAMPLES_PER_BIT-1: set `sc`=0, `bc`=0, go to DATA.
  - Otherwise increment `sc`.
- DATA:
  - `tx` = shift[0].
  - When `sc` wraps: shift right and increment `bc`.
  - Wrap with `bc`=6: go to STOP.
- STOP:
  - `tx`=1 for STOP_BITS × SAMPLES_PER_BIT ticks.
  - On the last tick: pulse `frame_done`.
  - If `hold_full`, load the next codeword and go straight to START. Otherwise go to IDLE.
- `ena`=0: `sc`, `bc`, state and `tx` hold. The handshake still operates.
- Illegal state encoding: next cycle goes to IDLE with `tx`=1.
- Reset:
  - Outputs: `tx`=1, `busy`=0, `data_ready`=1, `frame_done`=0, `state_out`=0.
  - Internal: `hold_full`=0, counters 0.
  - A reset asserted mid-frame aborts the frame and discards a pending nibble. `tx` is 1 on the next edge.

## Timing
- All outputs are registered.
- Frame length: (1 + 7 + STOP_BITS) × SAMPLES_PER_BIT `ena` ticks. This is 72 with defaults.
- Accept-to-start latency with `ena` held high, from IDLE:
  - Accept on edge N.
  - `hold_full`=1 after N; the IDLE→START transfer happens on edge N+1.
  - `tx` falls after edge N+1; `data_ready` returns to 1 after edge N+1.
- Back-to-back frames: a second nibble accepted any time before the final stop tick gives a start bit immediately after the stop bit(s), with zero idle ticks.
- A nibble offered while `hold_full`=1 is not accepted (`data_ready`=0). The offering side must hold `data_valid` and `data_in` until accepted.
- `busy` rises with the START transition. It falls on the edge after the final stop tick, unless a back-to-back frame follows.

## Test plan
- Reset, then idle 20 cycles with `ena`=1 → `tx`=1, `busy`=0, `data_ready`=1, `state_out`=0 throughout.
- Send 4'b1011, `ena`=1 every cycle → line carries 0 for 8 cycles, then 1,0,1,0,1,0,1 (8 cycles each), then 1 for 8 cycles. The loopback receiver outputs 7'h55 with its valid flag. `frame_done` pulses once.
- Send 4'h0, then 4'hF back-to-back → codewords 7'h00 and 7'h7F. No idle tick between the first stop bit and the second start bit. `data_ready` drops while the second nibble waits.
- `ena` asserted one cycle in four, nibble 4'h6 (c=7'h33) → each bit lasts 32 clocks. Decoded value is correct. The handshake still accepts on non-`ena` cycles.
- Assert `rst` for one cycle mid-DATA with a pending nibble → next edge: `tx`=1, state IDLE, `data_ready`=1. No frame follows.
- Hold `data_valid` continuously with an incrementing nibble for 16 frames → every nibble is sent exactly once, in order, with all 16 codewords matching the encoding equations.

Source files
------------

// File: rtl/uart_hamming_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_hamming_transmitter
// Description : Serial transmit side of a Hamming(7,4) UART link. A 4-bit
//               nibble is accepted over a valid/ready handshake into a
//               one-entry holding register, encoded into a 7-bit Hamming
//               codeword and sent as an idle-high UART frame
//               (start, 7 data bits LSB first, STOP_BITS stop bits). Frame
//               timing advances only on cycles where ena_i is high.
// Ports       : clk            clock, all logic on the rising edge
//               rst            synchronous active-high reset
//               ena_i          oversampling tick
//               data_in_i[3:0] nibble to send
//               data_valid_i   data_in_i is valid this cycle
//               data_ready_o   holding register empty (registered)
//               tx_o           serial line, idle high (registered)
//               busy_o         a frame is on the line (registered)
//               frame_done_o   pulse on the last tick of the final stop bit
//               state_out_o    current FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hamming_transmitter #(
    parameter int SAMPLES_PER_BIT = 8,
    parameter int STOP_BITS       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena_i,
    input  logic [3:0] data_in_i,
    input  logic       data_valid_i,
    output logic       data_ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic [1:0] state_out_o
);

    localparam int                c_SC_W         = $clog2(SAMPLES_PER_BIT);
    localparam logic [c_SC_W-1:0] c_SC_LAST      = c_SC_W'(SAMPLES_PER_BIT - 1);
    localparam logic [c_SC_W-1:0] c_SC_ONE       = c_SC_W'(1);
    localparam logic [2:0]        c_BC_DATA_LAST = 3'd6;
    localparam logic [2:0]        c_BC_STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // Codeword layout c[6:0] = {d3, d2, d1, p4, d0, p2, p1}; c[0] goes first.
    function automatic logic [6:0] hamming_encode(input logic [3:0] d);
        logic p1;
        logic p2;
        logic p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    state_t            state_q, state_d;
    logic [c_SC_W-1:0] sc_q, sc_d;
    logic [2:0]        bc_q, bc_d;
    logic [6:0]        shift_q, shift_d;
    logic [3:0]        hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;

    logic w_accept;
    logic w_sc_wrap;

    // ready_q is only ever high while hold is empty, so an accept can never
    // coincide with the hold register being drained into the shifter.
    assign w_accept  = data_valid_i & ready_q;
    assign w_sc_wrap = (sc_q == c_SC_LAST);

    always_comb begin
        state_d      = state_q;
        sc_d         = sc_q;
        bc_d         = bc_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        frame_done_d = 1'b0;

        if (w_accept) begin
            hold_d      = data_in_i;
            hold_full_d = 1'b1;
        end

        if (ena_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        shift_d     = hamming_encode(hold_q);
                        hold_full_d = 1'b0;
                        sc_d        = '0;
                        state_d     = ST_START;
                    end
                end
                ST_START: begin
                    if (w_sc_wrap) begin
                        sc_d    = '0;
                        bc_d    = '0;
                        state_d = ST_DATA;
                    end else begin
                        sc_d = sc_q + c_SC_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_sc_wrap) begin
                        sc_d    = '0;
                        shift_d = {1'b0, shift_q[6:1]};
                        if (bc_q == c_BC_DATA_LAST) begin
                            bc_d    = '0;
                            state_d = ST_STOP;
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + c_SC_ONE;
                    end
                end
                ST_STOP: begin
                    // bc counts stop bits here, so STOP_BITS=2 needs no
                    // extra counter.
                    if (w_sc_wrap) begin
                        sc_d = '0;
                        if (bc_q == c_BC_STOP_LAST) begin
                            bc_d         = '0;
                            frame_done_d = 1'b1;
                            if (hold_full_q) begin
                                shift_d     = hamming_encode(hold_q);
                                hold_full_d = 1'b0;
                                state_d     = ST_START;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + c_SC_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sc_d    = '0;
                    bc_d    = '0;
                end
            endcase
        end

        ready_d = ~hold_full_d;
        busy_d  = (state_d != ST_IDLE);

        // tx is derived from the next state so the line is registered and
        // changes on the same edge as the state.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sc_q         <= '0;
            bc_q         <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            ready_q      <= 1'b1;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sc_q         <= sc_d;
            bc_q         <= bc_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            ready_q      <= ready_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign data_ready_o = ready_q;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;
    assign state_out_o  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_hamming_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_hamming_transmitter
// Description : Self-checking bench for uart_hamming_transmitter. Stimulus
//               pushes each accepted nibble into a scoreboard queue; a
//               separate monitor samples the line on every ena tick,
//               captures whole frames and compares them against a Hamming
//               reference built from parity-coverage rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hamming_transmitter;

    localparam int c_FRAME_TICKS = 72;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [3:0] din;
    logic       dv;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       fdone;
    logic [1:0] st;

    uart_hamming_transmitter #(
        .SAMPLES_PER_BIT(8),
        .STOP_BITS      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena_i       (ena),
        .data_in_i   (din),
        .data_valid_i(dv),
        .data_ready_o(ready),
        .tx_o        (tx),
        .busy_o      (busy),
        .frame_done_o(fdone),
        .state_out_o (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         ena_mode = 0;
    int         cyc = 0;
    logic [3:0] sb_q[$];
    int         frames_seen = 0;
    int         fd_count = 0;
    logic [6:0] last_code = '0;
    logic [6:0] prev_code = '0;
    int         last_gap = -1;

    // Hamming(7,4): data sits at positions 3,5,6,7; parity bit at position
    // 2^k covers every other position whose index has bit k set.
    function automatic logic [6:0] model_encode(input logic [3:0] d);
        logic [7:1] pos;
        logic       par;
        pos    = '0;
        pos[3] = d[0];
        pos[5] = d[1];
        pos[6] = d[2];
        pos[7] = d[3];
        for (int pb = 1; pb <= 4; pb = pb * 2) begin
            par = 1'b0;
            for (int i = 1; i <= 7; i++)
                if (((i & pb) != 0) && (i != pb)) par = par ^ pos[i];
            pos[pb] = par;
        end
        return pos[7:1];
    endfunction

    function automatic logic [71:0] model_wave(input logic [6:0] c);
        logic [71:0] w;
        for (int t = 0; t < 72; t++) begin
            if (t < 8)       w[t] = 1'b0;
            else if (t < 64) w[t] = c[(t - 8) / 8];
            else             w[t] = 1'b1;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ena generator: always high, or one cycle in four.
    initial begin
        ena = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            ena = (ena_mode == 0) ? 1'b1 : ((cyc % 4) == 0);
        end
    end

    // Monitor: one record per ena tick, frames captured as 72-tick vectors.
    initial begin
        int          phase;
        int          idx;
        int          gap;
        logic [71:0] wav;
        logic [6:0]  code;
        logic [6:0]  exp_code;
        logic        busy_ok;
        logic        fd_check;
        logic        e;
        logic        r;
        phase    = 0;
        idx      = 0;
        gap      = 0;
        wav      = '0;
        busy_ok  = 1'b1;
        fd_check = 1'b0;
        forever begin
            @(posedge clk);
            e = ena;
            r = rst;
            #1;
            if (fdone) fd_count++;
            if (r) begin
                phase    = 0;
                fd_check = 1'b0;
                gap      = 0;
                continue;
            end
            if (!e) begin
                if (fdone) chk("frame_done_off_tick", 1, 0);
                continue;
            end
            if (fd_check) begin
                chk("frame_done_pulse", fdone, 1);
                fd_check = 1'b0;
            end else if (fdone) begin
                chk("frame_done_spurious", 1, 0);
            end
            if (phase == 0) begin
                if (tx == 1'b0) begin
                    phase    = 1;
                    idx      = 0;
                    wav      = '0;
                    busy_ok  = 1'b1;
                    last_gap = gap;
                    gap      = 0;
                end else begin
                    gap++;
                end
            end
            if (phase == 1) begin
                wav[idx] = tx;
                busy_ok  = busy_ok & busy;
                idx++;
                if (idx == c_FRAME_TICKS) begin
                    for (int b = 0; b < 7; b++) code[b] = wav[8 + 8 * b + 4];
                    if (sb_q.size() == 0) begin
                        chk("unexpected_frame", 1, 0);
                    end else begin
                        exp_code = model_encode(sb_q.pop_front());
                        chk("frame_wave", wav, model_wave(exp_code));
                        chk("frame_code", {65'd0, code}, {65'd0, exp_code});
                    end
                    chk("busy_in_frame", busy_ok, 1);
                    prev_code = last_code;
                    last_code = code;
                    frames_seen++;
                    fd_check = 1'b1;
                    phase    = 0;
                end
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 after the accept edge.
    task automatic send(input logic [3:0] d);
        int n;
        n   = 0;
        dv  = 1'b1;
        din = d;
        while (!ready && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!ready) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        sb_q.push_back(d);
        @(posedge clk);
        #1;
        chk("ready_drop", ready, 0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int n;
        n = 0;
        while (frames_seen < target && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("frames_timeout", frames_seen >= target, 1);
    endtask

    task automatic idle_cycles(input int n);
        dv = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs;
        int cnt;
        int n;
        rst = 1'b1;
        dv  = 1'b0;
        din = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_outputs", {tx, busy, ready, fdone, st}, 6'b101000);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            chk("idle_outputs", {tx, busy, ready, st}, 5'b10100);
        end

        // Single frame, nibble 1011 -> 7'h55.
        send(4'b1011);
        idle_cycles(1);
        wait_frames(1);
        chk("code_1011", {65'd0, last_code}, {65'd0, 7'h55});

        // Back-to-back 0 then F.
        send(4'h0);
        send(4'hF);
        idle_cycles(1);
        wait_frames(3);
        chk("code_b2b_first", {65'd0, prev_code}, {65'd0, 7'h00});
        chk("code_b2b_second", {65'd0, last_code}, {65'd0, 7'h7F});
        chk("b2b_gap", last_gap, 0);
        idle_cycles(5);

        // ena one cycle in four; accept on a non-ena cycle.
        ena_mode = 1;
        idle_cycles(2);
        n = 0;
        while (ena && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        send(4'h6);
        idle_cycles(1);
        n = 0;
        while (tx && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        cnt = 0;
        while (!tx && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        chk("start_bit_clocks", cnt, 32);
        wait_frames(4);
        chk("code_6", {65'd0, last_code}, {65'd0, 7'h33});
        ena_mode = 0;
        idle_cycles(5);

        // Reset mid-DATA with a pending nibble.
        send(4'h9);
        n = 0;
        while (st != 2'd2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_data", st, 2'd2);
        send(4'h5);
        dv  = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_reset", {tx, busy, ready, st}, 5'b10100);
        @(negedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        fs = frames_seen;
        idle_cycles(200);
        chk("no_frame_after_reset", frames_seen, fs);
        chk("idle_after_reset", {tx, busy, st}, 4'b1000);

        // 16 frames with data_valid held high, incrementing nibble.
        fs = frames_seen;
        for (int i = 0; i < 16; i++) send(4'(i));
        idle_cycles(1);
        wait_frames(fs + 16);
        chk("sb_empty_inc", sb_q.size(), 0);

        // Randomized nibbles, gaps and ena pacing.
        fs = frames_seen;
        for (int i = 0; i < 12; i++) begin
            ena_mode = int'($urandom_range(0, 1));
            idle_cycles(int'($urandom_range(0, 90)));
            send(4'($urandom));
        end
        idle_cycles(1);
        wait_frames(fs + 12);
        ena_mode = 0;
        idle_cycles(10);
        chk("sb_empty_rand", sb_q.size(), 0);
        chk("frame_done_count", fd_count, frames_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
